// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: instruction classes (common with the
// decoder), ALU/branch funct3 codes, EX FSM states and the combinational helpers.
package ex_pkg;

  localparam int unsigned DW = 32;

  typedef enum logic [4:0] {
    NOP    = 5'd0,
    R_ALU  = 5'd1,
    I_ALU  = 5'd2,
    LOAD   = 5'd3,
    STORE  = 5'd4,
    BRANCH = 5'd5,
    MUL    = 5'd6
  } inst_type_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    S_IDLE,
    S_MUL_RUN
  } ex_state_e;

  // sub selects SUB for funct3 000, arith selects SRA for funct3 101
  function automatic logic [DW-1:0] alu_op(input logic [2:0] f3, input logic sub,
                                           input logic arith, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [4:0]    sh;
    logic [DW-1:0] r;
    sh = b[4:0];
    r  = '0;
    case (f3)
      F3_ADD:  r = sub ? (a - b) : (a + b);
      F3_SLL:  r = a << sh;
      F3_SLT:  r = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      F3_SLTU: r = {{(DW-1){1'b0}}, (a < b)};
      F3_XOR:  r = a ^ b;
      F3_SRL:  r = arith ? DW'($signed(a) >>> sh) : (a >> sh);
      F3_OR:   r = a | b;
      F3_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = ($signed(a) < $signed(b));
      F3_BGE:  t = ($signed(a) >= $signed(b));
      F3_BLTU: t = (a < b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per step, low word only.
module seq_multiplier
  import ex_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            abort,
  input  logic [XLEN-1:0] mcand_in,
  input  logic [XLEN-1:0] mplier_in,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(MUL_STEPS);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] product;
  logic [CW-1:0]   cnt;

  assign last   = (cnt == CW'(MUL_STEPS - 1));
  // product after the current step; on the last step this is the final answer
  assign result = product + (mplier[0] ? mcand : '0);

  // load on start, advance one bit per step, clear the counter on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      mcand   <= mcand_in;
      mplier  <= mplier_in;
      product <= '0;
      cnt     <= '0;
    end else if (step) begin
      product <= result;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/address/branch, iterative MUL with upstream stall.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] immx,
  input  logic [4:0]      inst_type,
  input  logic            flush,
  output logic            stall_out,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch_taken
);

  ex_state_e       state;
  inst_type_e      itype;
  logic [2:0]      f3;
  logic [4:0]      rd_f;
  logic            alt;
  logic [XLEN-1:0] opb_sel;
  logic [XLEN-1:0] alu_val;
  logic [XLEN-1:0] addr_sum;
  logic            br_val;
  logic [4:0]      mul_rd;
  logic            mul_accept;
  logic            mul_step;
  logic            mul_abort;
  logic            mul_last;
  logic [XLEN-1:0] mul_result;
  logic            unused_bits;

  assign itype       = inst_type_e'(inst_type);
  assign f3          = inst[14:12];
  assign rd_f        = inst[11:7];
  assign alt         = inst[30];
  assign unused_bits = ^{inst[31], inst[29:15], inst[6:0]};

  // flush suppresses both a new accept and the remaining run cycles
  assign mul_accept = (state == S_IDLE) && in_valid && (itype == MUL) && !flush;
  assign mul_step   = (state == S_MUL_RUN) && !flush;
  assign mul_abort  = (state == S_MUL_RUN) && flush;
  assign stall_out  = mul_accept || (mul_step && !mul_last);

  assign opb_sel  = (itype == R_ALU) ? op_b : immx;
  assign alu_val  = alu_op(f3, (itype == R_ALU) && alt, alt, op_a, opb_sel);
  assign addr_sum = op_a + immx;
  assign br_val   = branch_cond(f3, op_a, op_b);

  seq_multiplier #(
    .XLEN      (XLEN),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_accept),
    .step      (mul_step),
    .abort     (mul_abort),
    .mcand_in  (op_a),
    .mplier_in (op_b),
    .last      (mul_last),
    .result    (mul_result)
  );

  // FSM plus EX/MEM output register; strobes default low, data outputs hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mul_rd       <= '0;
      out_valid    <= 1'b0;
      alu_result   <= '0;
      store_data   <= '0;
      rd           <= '0;
      reg_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      reg_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      branch_taken <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            case (itype)
              R_ALU, I_ALU: begin
                out_valid  <= 1'b1;
                alu_result <= alu_val;
                rd         <= rd_f;
                reg_write  <= (rd_f != '0);
              end
              LOAD: begin
                out_valid  <= 1'b1;
                alu_result <= addr_sum;
                rd         <= rd_f;
                reg_write  <= (rd_f != '0);
                mem_read   <= 1'b1;
              end
              STORE: begin
                out_valid  <= 1'b1;
                alu_result <= addr_sum;
                store_data <= op_b;
                rd         <= rd_f;
                mem_write  <= 1'b1;
              end
              BRANCH: begin
                out_valid    <= 1'b1;
                alu_result   <= '0;
                rd           <= rd_f;
                branch_taken <= br_val;
              end
              MUL: begin
                state  <= S_MUL_RUN;
                mul_rd <= rd_f;
              end
              default: ;
            endcase
          end
        end
        S_MUL_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (mul_last) begin
            out_valid  <= 1'b1;
            alu_result <= mul_result;
            rd         <= mul_rd;
            reg_write  <= (mul_rd != '0);
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized single-cycle
// ops against an arithmetic reference model, and hand-written MUL/flush/reset sequences.
module tb_ex_stage;

  localparam logic [4:0] T_NOP = 5'd0, T_R = 5'd1, T_I = 5'd2, T_LD = 5'd3,
                         T_ST = 5'd4, T_BR = 5'd5, T_MUL = 5'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst, op_a, op_b, immx;
  logic [4:0]  inst_type;
  logic        flush;
  logic        stall_out, out_valid, reg_write, mem_read, mem_write, branch_taken;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .MUL_STEPS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inst(inst), .op_a(op_a),
    .op_b(op_b), .immx(immx), .inst_type(inst_type), .flush(flush),
    .stall_out(stall_out), .out_valid(out_valid), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch_taken(branch_taken)
  );

  typedef struct {
    logic [4:0]  t;
    logic [31:0] inst, a, b, imm;
    logic        iv, fl;
    logic        ev;
    logic [31:0] eres;
    logic        erw, emr, emw, ebt;
    logic [31:0] esd;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw, mr, mw, bt, sdu;
    logic [31:0] sd;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic alt, input logic [2:0] f3,
                                          input logic [4:0] rdn);
    return {1'b0, alt, 15'b0, f3, rdn, 7'b0110011};
  endfunction

  function automatic vec_t mkv(input logic [4:0] t, input logic alt, input logic [2:0] f3,
                               input logic [4:0] rdn, input logic [31:0] a, b, imm,
                               input logic iv, fl, ev, input logic [31:0] eres,
                               input logic erw, emr, emw, ebt, input logic [31:0] esd);
    vec_t v;
    v.t = t; v.inst = mk_inst(alt, f3, rdn); v.a = a; v.b = b; v.imm = imm;
    v.iv = iv; v.fl = fl; v.ev = ev; v.eres = eres;
    v.erw = erw; v.emr = emr; v.emw = emw; v.ebt = ebt; v.esd = esd;
    return v;
  endfunction

  // reference: the architectural meaning of each instruction class
  function automatic exp_t ref_model(input logic [4:0] t, input logic [31:0] iw, a, b, imm,
                                     input logic iv, fl);
    exp_t        e;
    logic [31:0] bo;
    int unsigned sh;
    logic [2:0]  f3;
    e  = '{v: 1'b0, res: '0, rd: '0, rw: 1'b0, mr: 1'b0, mw: 1'b0, bt: 1'b0, sdu: 1'b0, sd: '0};
    f3 = iw[14:12];
    if (!iv || fl) return e;
    e.rd = iw[11:7];
    case (t)
      T_R, T_I: begin
        bo = (t == T_R) ? b : imm;
        sh = bo % 32;
        case (f3)
          3'd0: e.res = (t == T_R && iw[30]) ? a - bo : a + bo;
          3'd1: e.res = a << sh;
          3'd2: e.res = ($signed(a) < $signed(bo)) ? 32'd1 : 32'd0;
          3'd3: e.res = (a < bo) ? 32'd1 : 32'd0;
          3'd4: e.res = a ^ bo;
          3'd5: e.res = iw[30] ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: e.res = a | bo;
          default: e.res = a & bo;
        endcase
        e.v = 1'b1; e.rw = (e.rd != 0);
      end
      T_LD: begin e.v = 1'b1; e.res = a + imm; e.rw = (e.rd != 0); e.mr = 1'b1; end
      T_ST: begin e.v = 1'b1; e.res = a + imm; e.mw = 1'b1; e.sdu = 1'b1; e.sd = b; end
      T_BR: begin
        e.v = 1'b1;
        case (f3)
          3'd0: e.bt = (a == b);
          3'd1: e.bt = (a != b);
          3'd4: e.bt = ($signed(a) < $signed(b));
          3'd5: e.bt = ($signed(a) >= $signed(b));
          3'd6: e.bt = (a < b);
          3'd7: e.bt = (a >= b);
          default: e.bt = 1'b0;
        endcase
      end
      default: e.v = 1'b0;
    endcase
    return e;
  endfunction

  task automatic drive(input logic [4:0] t, input logic [31:0] iw, a, b, imm,
                       input logic iv, fl);
    @(negedge clk);
    inst_type = t; inst = iw; op_a = a; op_b = b; immx = imm; in_valid = iv; flush = fl;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_result"}, alu_result, 32'd0);
    check({tag, "_sdata"}, store_data, 32'd0);
    check({tag, "_rd"}, 32'(rd), 32'd0);
    check({tag, "_ctrl"}, {28'd0, reg_write, mem_read, mem_write, branch_taken}, 32'd0);
    check({tag, "_stall"}, 32'(stall_out), 32'd0);
  endtask

  task automatic single_add(input logic [31:0] a, b, input logic [4:0] rdn, input string tag);
    drive(T_R, mk_inst(1'b0, 3'd0, rdn), a, b, 32'd0, 1'b1, 1'b0);
    #1 check({tag, "_stall"}, 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, alu_result, a + b);
    check({tag, "_rw"}, 32'(reg_write), 32'(rdn != 0));
    in_valid = 1'b0;
  endtask

  // MUL sequence; flush_at > 0 asserts flush in that run cycle
  task automatic run_mul(input logic [31:0] a, b, input logic [4:0] rdn, input int flush_at);
    int stalls  = 0;
    int done_at = 0;
    int spur    = 0;
    logic [31:0] prod;
    prod = a * b;
    drive(T_MUL, mk_inst(1'b0, 3'd0, rdn), a, b, 32'd0, 1'b1, 1'b0);
    #1;
    check("mul_accept_stall", 32'(stall_out), 32'd1);
    if (stall_out) stalls++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin done_at = k; break; end
      if (k == flush_at) begin
        flush = 1'b1; in_valid = 1'b0;
        #1 check("mul_flush_stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("mul_flush_valid", 32'(out_valid), 32'd0);
        for (int j = 0; j < 36; j++) begin
          @(posedge clk); #1;
          if (out_valid || stall_out) spur++;
        end
        check("mul_flush_no_result", 32'(spur), 32'd0);
        done_at = -1;
        break;
      end
      if (stall_out) stalls++;
      else in_valid = 1'b0;
    end
    if (flush_at <= 0) begin
      check("mul_stall_cycles", 32'(stalls), 32'd32);
      check("mul_latency", 32'(done_at), 32'd33);
      check("mul_result", alu_result, prod);
      check("mul_rd", 32'(rd), 32'(rdn));
      check("mul_rw", 32'(reg_write), 32'(rdn != 0));
      check("mul_memctl", {30'd0, mem_read, mem_write}, 32'd0);
      @(posedge clk); #1;
      check("mul_after_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  vec_t        vecs[$];
  exp_t        e;
  logic [31:0] h_res, h_sd, ra, rb, ri, riw;
  logic [4:0]  h_rd, rt;
  logic        sd_known, riv, rfl;
  int          sel;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; inst = '0; op_a = '0; op_b = '0; immx = '0;
    inst_type = T_NOP; flush = 1'b0;
    #2 check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //           type  alt f3 rd  a             b             imm           iv fl ev res           rw mr mw bt sd
    vecs.push_back(mkv(T_R, 0, 0, 3, 32'd5,        32'd7,        32'd0,        1, 0, 1, 32'd12,       1, 0, 0, 0, 0));
    vecs.push_back(mkv(T_R, 1, 0, 4, 32'd0,        32'd1,        32'd0,        1, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(T_I, 1, 5, 5, 32'h80000000, 32'd0,        32'h404,      1, 0, 1, 32'hF8000000, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(T_I, 0, 5, 5, 32'h80000000, 32'd0,        32'd4,        1, 0, 1, 32'h08000000, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(T_BR,0, 6, 1, 32'd1,        32'hFFFFFFFF, 32'd0,        1, 0, 1, 32'd0,        0, 0, 0, 1, 0));
    vecs.push_back(mkv(T_BR,0, 4, 1, 32'd1,        32'hFFFFFFFF, 32'd0,        1, 0, 1, 32'd0,        0, 0, 0, 0, 0));
    vecs.push_back(mkv(T_R, 0, 0, 0, 32'd5,        32'd7,        32'd0,        1, 0, 1, 32'd12,       0, 0, 0, 0, 0));
    vecs.push_back(mkv(T_LD,0, 2, 6, 32'h1000,     32'd0,        32'hFFFFFFFC, 1, 0, 1, 32'hFFC,      1, 1, 0, 0, 0));
    vecs.push_back(mkv(T_ST,0, 2, 9, 32'h2000,     32'hDEADBEEF, 32'd8,        1, 0, 1, 32'h2008,     0, 0, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mkv(T_I, 0, 2, 7, 32'hFFFFFFFF, 32'd0,        32'd0,        1, 0, 1, 32'd1,        1, 0, 0, 0, 0));
    vecs.push_back(mkv(T_I, 0, 3, 7, 32'hFFFFFFFF, 32'd0,        32'd0,        1, 0, 1, 32'd0,        1, 0, 0, 0, 0));
    vecs.push_back(mkv(T_I, 1, 0, 8, 32'd10,       32'd0,        32'd5,        1, 0, 1, 32'd15,       1, 0, 0, 0, 0));
    vecs.push_back(mkv(T_R, 0, 1, 2, 32'd1,        32'h21,       32'd0,        1, 0, 1, 32'd2,        1, 0, 0, 0, 0));
    vecs.push_back(mkv(T_BR,0, 0, 1, 32'd7,        32'd7,        32'd0,        1, 0, 1, 32'd0,        0, 0, 0, 1, 0));
    vecs.push_back(mkv(T_BR,0, 1, 1, 32'd7,        32'd7,        32'd0,        1, 0, 1, 32'd0,        0, 0, 0, 0, 0));
    vecs.push_back(mkv(T_BR,0, 2, 1, 32'd7,        32'd7,        32'd0,        1, 0, 1, 32'd0,        0, 0, 0, 0, 0));
    vecs.push_back(mkv(T_BR,0, 7, 1, 32'd7,        32'd7,        32'd0,        1, 0, 1, 32'd0,        0, 0, 0, 1, 0));
    vecs.push_back(mkv(T_R, 0, 0, 3, 32'd5,        32'd7,        32'd0,        0, 0, 0, 32'd0,        0, 0, 0, 0, 0));
    vecs.push_back(mkv(5'd9,0, 0, 3, 32'd5,        32'd7,        32'd0,        1, 0, 0, 32'd0,        0, 0, 0, 0, 0));
    vecs.push_back(mkv(T_NOP,0,0, 3, 32'd5,        32'd7,        32'd0,        1, 0, 0, 32'd0,        0, 0, 0, 0, 0));
    vecs.push_back(mkv(T_LD,0, 0, 3, 32'd5,        32'd7,        32'd0,        1, 1, 0, 32'd0,        0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].t, vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].iv, vecs[i].fl);
      #1 check($sformatf("vec%0d_stall", i), 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_ctrl", i), {28'd0, reg_write, mem_read, mem_write, branch_taken},
            {28'd0, vecs[i].erw, vecs[i].emr, vecs[i].emw, vecs[i].ebt});
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_result", i), alu_result, vecs[i].eres);
        check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].inst[11:7]));
      end
      if (vecs[i].ev && vecs[i].t == T_ST)
        check($sformatf("vec%0d_sdata", i), store_data, vecs[i].esd);
    end

    // randomized single-cycle traffic, including bubbles and flushes
    single_add(32'd1, 32'd2, 5'd1, "rnd_seed");
    h_res = 32'd3; h_rd = 5'd1; h_sd = '0; sd_known = 1'b0;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rt = T_NOP;
        1, 2:    rt = T_R;
        3, 4:    rt = T_I;
        5:       rt = T_LD;
        6:       rt = T_ST;
        7, 8:    rt = T_BR;
        default: rt = 5'($urandom_range(7, 31));
      endcase
      riw = $urandom; ra = $urandom; rb = $urandom; ri = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      if ($urandom_range(0, 3) == 0) ri = 32'($signed(ri[11:0]));
      riv = ($urandom_range(0, 7) != 0);
      rfl = ($urandom_range(0, 7) == 0);
      e = ref_model(rt, riw, ra, rb, ri, riv, rfl);
      if (e.v) begin h_res = e.res; h_rd = e.rd; end
      if (e.sdu) begin h_sd = e.sd; sd_known = 1'b1; end
      drive(rt, riw, ra, rb, ri, riv, rfl);
      #1 check("rnd_stall", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      check("rnd_valid", 32'(out_valid), 32'(e.v));
      check("rnd_result", alu_result, h_res);
      check("rnd_rd", 32'(rd), 32'(h_rd));
      check("rnd_ctrl", {28'd0, reg_write, mem_read, mem_write, branch_taken},
            {28'd0, e.rw, e.mr, e.mw, e.bt});
      if (sd_known) check("rnd_sdata", store_data, h_sd);
    end
    in_valid = 1'b0; flush = 1'b0;

    // MUL corner cases
    run_mul(32'h10001, 32'h10001, 5'd10, 0);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 0);
    run_mul(32'h12345678, 32'd0, 5'd0, 0);
    for (int n = 0; n < 3; n++) run_mul($urandom, $urandom, 5'($urandom_range(1, 31)), 0);
    run_mul(32'h10001, 32'h10001, 5'd12, 10);
    single_add(32'd100, 32'd23, 5'd7, "post_flush_add");

    // flushed MUL presentation is never accepted
    drive(T_MUL, mk_inst(1'b0, 3'd0, 5'd4), 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
    #1 check("mul_flush_idle_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    check("mul_flush_idle_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0; flush = 1'b0;
    single_add(32'd9, 32'd1, 5'd2, "post_idle_flush_add");

    // asynchronous reset aborts a running MUL
    single_add(32'd5, 32'd7, 5'd3, "pre_reset_add");
    drive(T_MUL, mk_inst(1'b0, 3'd0, 5'd5), 32'd6, 32'd7, 32'd0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0; in_valid = 1'b0;
    #1 check_zero_outputs("midmul_reset");
    @(negedge clk); rst_n = 1'b1;
    single_add(32'd20, 32'd22, 5'd0, "post_reset_add_rd0");
    check("post_reset_rd", 32'(rd), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. Consumes the decoded instruction, operands, immediate and instruction type from the ID/EX pipeline register.
- Produces a registered result bundle for the EX/MEM register.
- Single-cycle ALU, address and branch ops complete in one cycle.
- MUL runs an iterative 32-step shift-add FSM and drives stall_out back to the ID/EX register and the fetch/decode stages.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MUL_STEPS, 32, iteration count of the multiplier; must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ID/EX holds a live instruction
- inst  input  32  raw instruction word
- op_a  input  32  rs1 value
- op_b  input  32  rs2 value
- immx  input  32  sign-extended immediate
- inst_type  input  5  decoded class (see package)
- flush  input  1  kill the in-flight instruction (branch redirect)
- stall_out  output  1  hold ID/EX and upstream stages this cycle
- out_valid  output  1  result bundle valid
- alu_result  output  32  ALU result, effective address, or product low word
- store_data  output  32  op_b passed through for STORE
- rd  output  5  destination register = inst[11:7]
- reg_write  output  1  write rd (forced 0 when rd==0)
- mem_read  output  1  LOAD
- mem_write  output  1  STORE
- branch_taken  output  1  BRANCH condition true

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0. Reset is asynchronous and may abort a running MUL.
- FSM states: IDLE, MUL_RUN.
- IDLE with in_valid and a non-MUL type: outputs registered at the next edge (1-cycle latency); out_valid=1; stall_out=0.
- R / I ALU ops, selected by inst[14:12]:
  - 000: ADD; SUB when R-type and inst[30]=1.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL; SRA when inst[30]=1.
  - 110: OR.
  - 111: AND.
  - Operand B is op_b for R-type and immx for I-type.
  - Shift amount = B[4:0].
  - Arithmetic wraps modulo 2^32.
- LOAD / STORE: alu_result = op_a + immx (wraps); store_data = op_b.
- BRANCH, selected by inst[14:12]:
  - BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - 010 and 011: branch_taken=0.
  - alu_result=0 and reg_write=0.
- NOP, unknown type, or in_valid=0: out_valid=0 and all control outputs 0 next cycle.
- MUL accept (IDLE, in_valid, MUL type, flush=0):
  - stall_out=1 combinationally.
  - At the edge: latch multiplicand=op_a, multiplier=op_b, product=0, cnt=0, rd; go to MUL_RUN; out_valid=0.
- MUL_RUN, each cycle:
  - If multiplier[0], add the multiplicand to product.
  - Shift multiplicand left by 1 and multiplier right by 1; cnt++.
  - stall_out=1 while cnt<31; stall_out=0 at cnt==31.
  - Inputs are ignored in this state.
- Last step (cnt==31): at the edge, alu_result = low 32 bits of the final product, reg_write per rd, out_valid=1, state returns to IDLE.
- MUL timing: total occupancy is 33 cycles from presentation to out_valid; stall_out is high for 32 cycles.
- flush has priority over everything:
  - No accept; next-cycle out_valid=0 and all control outputs 0.
  - If in MUL_RUN, abort to IDLE; stall_out=0 in the flush cycle.
- Outputs hold their value between valid results, except out_valid and the control strobes, which are 0 during bubbles.

Decomposition:
- Package ex_pkg holds the inst_type encodings and the funct3 constants for ALU and branch ops:
  - NOP=0, R_ALU=1, I_ALU=2, LOAD=3, STORE=4, BRANCH=5, MUL=6.
  - The same encodings are shared with the decoder.
- One sub-module, seq_multiplier, holds the shift-add datapath and counter with start/abort/done. The top keeps the single-cycle ALU, branch compare and output register.

Test Plan:
- R ADD: op_a=5, op_b=7, funct3=000, inst[30]=0, rd=3 -> next cycle alu_result=12, reg_write=1, out_valid=1.
- R SUB: op_a=0, op_b=1, inst[30]=1 -> alu_result=0xFFFFFFFF. I SRAI: op_a=0x80000000, imm shamt=4, inst[30]=1 -> alu_result=0xF8000000.
- BLTU: op_a=1, op_b=0xFFFFFFFF -> branch_taken=1. BLT with the same operands -> branch_taken=0. In both cases reg_write=0.
- MUL: op_a=0x10001, op_b=0x10001 -> stall_out high for 32 cycles; out_valid on cycle 33 with alu_result=0x00020001.
- MUL with flush asserted in run cycle 10 -> stall_out drops in that cycle; out_valid=0; the next ADD completes normally.
- rst_n low mid-MUL -> all outputs 0 immediately, state IDLE; rd=0 on an ADD -> reg_write=0.
